dff_write_arbiter: RTL and testbench
====================================

# dff_write_arbiter

Round-robin write arbiter that shares one `dff` register (width `n`) among `R` requesters. Each cycle it selects at most one requesting client and drives the register's `d`/`en` inputs with that client's data. It also supports a lock for multi-cycle ownership. It sits directly in front of a `dff` instance, with `reg_d`/`reg_en` wired to that instance's `d`/`en`.

## Interface
- `n`, default 8: data width; matches the target `dff` parameter.
- `R`, default 4: number of requesters; legal range 2..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input R: write request, one bit per requester.
- `lock` input R: when high together with `req[i]`, requester i keeps ownership while granted.
- `wdata` input R*n: requester i's data is `wdata[i*n +: n]`.
- `gnt` output R: one-hot write acknowledge; bit i high means requester i's data is written this cycle.
- `reg_d` output n: data to the register's `d`.
- `reg_en` output 1: write enable to the register's `en`.
- `owner` output log2(R): index of the last or current granted requester.
- `locked` output 1: high while the arbiter is in LOCK.
- `wr_count` output 16: total granted writes since reset; wraps at 16'hFFFF to 0.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `reg_d`=0, `reg_en`=0, `owner`=0, `locked`=0, `wr_count`=0. The internal state is IDLE and the priority pointer `ptr` is 0.
- Round-robin selection:
  - The winner is the first i with `req[i]`=1, scanning from `ptr` upward modulo R.
  - After a grant to i, `ptr` becomes (i+1) mod R.
  - `ptr` is unchanged when nothing is granted.
- States:
  - IDLE: no grant outputs active. If any `req` is high, grant the winner w and go to GRANT. If `lock[w]` is also high, go to LOCK instead.
  - GRANT: a single write was issued. Re-arbitrate this cycle exactly as in IDLE, so back-to-back writes from different requesters are legal. If no `req` is high, go to IDLE.
  - LOCK: `owner` is fixed.
    - While `req[owner]`=1 and `lock[owner]`=1, grant owner every cycle and ignore other requests.
    - If `lock[owner]` drops while `req[owner]`=1, grant owner one final time and go to GRANT.
    - If `req[owner]` drops, issue no grant and re-arbitrate next cycle from IDLE rules, with `ptr`=(owner+1) mod R.
- Every grant does all of the following:
  - sets `gnt` one-hot;
  - sets `reg_en`=1;
  - sets `reg_d` to the winner's `wdata`;
  - sets `owner` to the winner index;
  - increments `wr_count` by 1.
- Non-grant cycles: `gnt`=0 and `reg_en`=0. `reg_d` and `owner` hold their previous values.
- `lock[i]` with `req[i]`=0 is ignored.
- Requester contract: a requester holds `req` and stable `wdata` until it sees its `gnt` bit. A requester that drops `req` before its grant is simply not granted; this is not an error.
- Starvation bound: a continuously requesting client that is not blocked by a lock is granted within R cycles.

## Timing
- Latency: `req`/`wdata` sampled at rising edge t are reflected in `gnt`/`reg_en`/`reg_d` after edge t, i.e. visible during cycle t+1. The `dff` captures the data at edge t+1.
- Throughput: one write per cycle maximum.
- Simultaneous requests are resolved in the same edge by the `ptr` scan; there is no extra cycle.
- `rst` asserted mid-LOCK or mid-GRANT forces all outputs and state to their reset values immediately, without waiting for a clock edge. The first arbitration after `rst` deasserts occurs at the next rising edge, with requester 0 highest priority.
- `wr_count` wrap: a grant at 16'hFFFF yields 0 on the same edge.

## Test plan
- Reset: hold `rst`=1 with `req`=4'b1111 → `gnt`=0, `reg_en`=0, `reg_d`=0, `wr_count`=0. Release `rst` → next edge `gnt`=4'b0001.
- Round-robin: R=4, `req`=4'b1111 held for 8 cycles with `wdata[i]`=8'h10+i → `gnt` sequence 0001, 0010, 0100, 1000, repeating. `reg_d` follows 8'h10, 8'h11, 8'h12, 8'h13. `wr_count`=8.
- Sparse: `req`=4'b1010 held → `gnt` alternates 0010, 1000. `req` all 0 → `reg_en`=0 next cycle; state IDLE, `ptr` retained.
- Lock: `req`=4'b0101, `lock`=4'b0001 for 3 cycles, then `lock`=0 → `gnt`=0001 for 3 cycles plus one final grant, then 0100. `locked`=1 only during the lock cycles.
- Lock abort: in LOCK, drop `req[owner]` → one cycle `reg_en`=0, then the next requester after owner is granted.
- Reset mid-LOCK and counter wrap: assert `rst` during LOCK → `locked`=0 and `gnt`=0 asynchronously. Separately, preload `wr_count` to 16'hFFFE by running 65534 grants, then issue 2 grants → `wr_count`=0.

Source files
------------

// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin write arbiter with lock in front of a shared dff
//
// Shares one dff register (width n) among R requesters. Each cycle at most one
// requesting client wins by round-robin scan from ptr; its data is driven onto
// reg_d with reg_en. A requester holding lock together with req keeps ownership
// across cycles until it drops lock (one final write) or req (no write).
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req       [R-1:0]   write request per requester
//   lock      [R-1:0]   ownership hold per requester (only meaningful with req)
//   wdata     [R*n-1:0] requester i data at wdata[i*n +: n]
//   gnt       [R-1:0]   one-hot write acknowledge, registered
//   reg_d     [n-1:0]   data to dff d, holds between writes
//   reg_en              write enable to dff en
//   owner     [OW-1:0]  last or current granted requester
//   locked              high while in LOCK
//   wr_count  [15:0]    granted writes since reset, wrapping
module dff_write_arbiter #(
  parameter int n = 8,
  parameter int R = 4,
  localparam int OW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req,
  input  logic [R-1:0]    lock,
  input  logic [R*n-1:0]  wdata,
  output logic [R-1:0]    gnt,
  output logic [n-1:0]    reg_d,
  output logic            reg_en,
  output logic [OW-1:0]   owner,
  output logic            locked,
  output logic [15:0]     wr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;

  // Round-robin winner: first requesting index scanning upward from ptr.
  logic          found;
  logic [OW-1:0] win;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // In LOCK the owner is the only candidate; elsewhere the scan winner.
  logic          do_grant;
  logic [OW-1:0] sel;
  logic [OW-1:0] sel_next;
  logic [R-1:0]  sel_onehot;

  always_comb begin
    if (state == S_LOCK) begin
      do_grant = req[owner];
      sel      = owner;
    end else begin
      do_grant = found;
      sel      = win;
    end
    sel_next = (sel == OW'(R - 1)) ? '0 : sel + OW'(1);
    sel_onehot = '0;
    for (int i = 0; i < R; i++) begin
      sel_onehot[i] = (OW'(i) == sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt      <= '0;
      reg_d    <= '0;
      reg_en   <= 1'b0;
      owner    <= '0;
      locked   <= 1'b0;
      wr_count <= '0;
    end else begin
      gnt    <= '0;
      reg_en <= 1'b0;
      if (do_grant) begin
        gnt      <= sel_onehot;
        reg_en   <= 1'b1;
        reg_d    <= wdata[int'(sel)*n +: n];
        owner    <= sel;
        wr_count <= wr_count + 16'd1;
      end

      // ptr always points past the most recent owner; in LOCK that is the
      // owner itself, so an abort resumes the scan just after it.
      if (do_grant || state == S_LOCK) ptr <= sel_next;

      case (state)
        S_LOCK: begin
          if (req[owner] && lock[owner]) begin
            state  <= S_LOCK;
            locked <= 1'b1;
          end else if (req[owner]) begin
            state  <= S_GRANT;
            locked <= 1'b0;
          end else begin
            state  <= S_IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          if (found && lock[win]) begin
            state  <= S_LOCK;
            locked <= 1'b1;
          end else if (found) begin
            state  <= S_GRANT;
            locked <= 1'b0;
          end else begin
            state  <= S_IDLE;
            locked <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb/tb_dff_write_arbiter.sv - scoreboard bench for dff_write_arbiter
module tb_dff_write_arbiter;

  localparam int N  = 8;
  localparam int RR = 4;

  logic          clk;
  logic          rst;
  logic [RR-1:0] req;
  logic [RR-1:0] lock;
  logic [RR*N-1:0] wdata;
  logic [RR-1:0] gnt;
  logic [N-1:0]  reg_d;
  logic          reg_en;
  logic [1:0]    owner;
  logic          locked;
  logic [15:0]   wr_count;

  dff_write_arbiter #(.n(N), .R(RR)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .reg_d(reg_d), .reg_en(reg_en), .owner(owner),
    .locked(locked), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  gnt;
    logic [7:0]  d;
    logic [1:0]  owner;
    logic        locked;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   sb_on  = 1'b0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Apply inputs for the next edge; when a grant is expected, enqueue it
  // tagged with the cycle in which it must be visible.
  task automatic edge_exp(input logic [3:0] r, input logic [3:0] l,
                          input logic [3:0] eg, input logic el);
    exp_t e;
    req  = r;
    lock = l;
    if (eg != 4'b0) begin
      model_cnt = model_cnt + 16'd1;
      e.cyc    = cyc + 1;
      e.gnt    = eg;
      e.owner  = idx_of(eg);
      e.d      = 8'h10 + {6'd0, idx_of(eg)};
      e.locked = el;
      e.cnt    = model_cnt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented write is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (sb_on && !rst) begin
      if (reg_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {28'd0, gnt}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_cycle", cyc, e.cyc);
          chk("gnt", {28'd0, gnt}, {28'd0, e.gnt});
          chk("reg_d", {24'd0, reg_d}, {24'd0, e.d});
          chk("owner", {30'd0, owner}, {30'd0, e.owner});
          chk("locked", {31'd0, locked}, {31'd0, e.locked});
          chk("wr_count", {16'd0, wr_count}, {16'd0, e.cnt});
        end
      end else begin
        chk("idle_gnt", {28'd0, gnt}, 32'd0);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset holds all outputs at zero despite requests.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_reg_en", {31'd0, reg_en}, 32'd0);
    chk("rst_reg_d", {24'd0, reg_d}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    rst   = 1'b0;
    sb_on = 1'b1;

    // Full round-robin, two rounds.
    for (int k = 0; k < 8; k++) edge_exp(4'b1111, 4'b0000, 4'b0001 << (k % 4), 1'b0);

    // Sparse requests, then idle keeps ptr (next winner is 2, not 0).
    edge_exp(4'b1010, 4'b0000, 4'b0010, 1'b0);
    edge_exp(4'b1010, 4'b0000, 4'b1000, 1'b0);
    edge_exp(4'b1010, 4'b0000, 4'b0010, 1'b0);
    edge_exp(4'b0000, 4'b0000, 4'b0000, 1'b0);
    edge_exp(4'b1111, 4'b0000, 4'b0100, 1'b0);
    edge_exp(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Lock for three cycles, final grant on unlock, then requester 2.
    edge_exp(4'b0101, 4'b0001, 4'b0001, 1'b1);
    edge_exp(4'b0101, 4'b0001, 4'b0001, 1'b1);
    edge_exp(4'b0101, 4'b0001, 4'b0001, 1'b1);
    edge_exp(4'b0101, 4'b0000, 4'b0001, 1'b0);
    edge_exp(4'b0101, 4'b0000, 4'b0100, 1'b0);
    edge_exp(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Lock abort: owner drops req, one empty cycle, resume after owner.
    edge_exp(4'b0011, 4'b0001, 4'b0001, 1'b1);
    edge_exp(4'b0011, 4'b0001, 4'b0001, 1'b1);
    edge_exp(4'b0010, 4'b0000, 4'b0000, 1'b0);
    chk("abort_locked", {31'd0, locked}, 32'd0);
    chk("abort_reg_en", {31'd0, reg_en}, 32'd0);
    edge_exp(4'b0110, 4'b0000, 4'b0010, 1'b0);
    edge_exp(4'b0110, 4'b0000, 4'b0100, 1'b0);
    // lock bits without req are ignored
    edge_exp(4'b0100, 4'b1011, 4'b0100, 1'b0);
    edge_exp(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-LOCK clears outputs without a clock edge.
    edge_exp(4'b0001, 4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    #1;
    sb_on = 1'b0;
    chk("prelock_locked", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_gnt", {28'd0, gnt}, 32'd0);
    chk("async_reg_en", {31'd0, reg_en}, 32'd0);
    chk("async_wr_count", {16'd0, wr_count}, 32'd0);

    // Counter wrap: continuous grants from reset.
    req  = 4'b1111;
    lock = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("wrap_fffe", {16'd0, wr_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    chk("wrap_ffff", {16'd0, wr_count}, 32'h0000_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_zero", {16'd0, wr_count}, 32'd0);
    chk("wrap_reg_en", {31'd0, reg_en}, 32'd1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
